// File: rtl/mii_tx_frame_arbiter.sv
// mii_tx_frame_arbiter
//   Round-robin arbiter that shares one wide MII transmit lane between
//   NUM_SRC frame sources. A grant covers a whole frame, so words of
//   different frames are never interleaved. Cycles with nothing to send
//   carry idle control words, and at least IPG_WORDS+1 idle words separate
//   consecutive frames on the lane.
//
// Ports
//   clk, rst_n    clock (rising edge) / asynchronous active-low reset
//   enable        1 = a new frame may be granted (checked in IDLE only)
//   req_valid     per-source word valid
//   req_data      source s word at [s*DATA_WIDTH +: DATA_WIDTH]
//   req_ctrl      source s byte ctrl flags at [s*CW +: CW]
//   req_last      per-source last-word-of-frame flag
//   req_ready     per-source accept (combinational, only granted source in XFER)
//   tx_data       registered lane data
//   tx_ctrl       registered lane ctrl flags (1 = control character)
//   grant_id      currently / most recently granted source
//   busy          1 while in XFER or GAP
//   frames_sent   completed frame count, wraps at 2^32

module mii_tx_frame_arbiter #(
   parameter int          DATA_WIDTH = 64,
   parameter int          NUM_SRC    = 4,
   parameter int          IPG_WORDS  = 2,
   parameter logic [7:0]  IDLE_CHAR  = 8'h07,
   localparam int         CW         = DATA_WIDTH / 8,
   localparam int         GW         = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_SRC-1:0]            req_valid,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_SRC*CW-1:0]         req_ctrl,
   input  logic [NUM_SRC-1:0]            req_last,
   output logic [NUM_SRC-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic [CW-1:0]                 tx_ctrl,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic [31:0]                   frames_sent
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [DATA_WIDTH-1:0] IDLE_DATA = {CW{IDLE_CHAR}};
   localparam logic [CW-1:0]         IDLE_CTRL = {CW{1'b1}};
   // GAP counts down to zero, so it is loaded with one less than its length
   localparam logic [3:0]            GAP_INIT  = (IPG_WORDS > 0) ? 4'(IPG_WORDS - 1) : 4'd0;

   logic [1:0]            state_q, state_d;
   logic [GW-1:0]         ptr_q, ptr_d;
   logic [GW-1:0]         grant_id_q, grant_id_d;
   logic [3:0]            gap_cnt_q, gap_cnt_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [CW-1:0]         tx_ctrl_q, tx_ctrl_d;
   logic [31:0]           frames_sent_q, frames_sent_d;
   logic                  busy_q, busy_d;

   // Round-robin search: first valid source after the last granted one
   logic          pick_found;
   logic [GW-1:0] pick_idx;
   always_comb begin
      int idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         idx = (int'(ptr_q) + i) % NUM_SRC;
         if (!pick_found && req_valid[idx]) begin
            pick_found = 1'b1;
            pick_idx   = GW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_XFER)
         req_ready[grant_id_q] = 1'b1;
   end

   logic hs;
   assign hs = (state_q == S_XFER) && req_valid[grant_id_q];

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      gap_cnt_d     = gap_cnt_q;
      frames_sent_d = frames_sent_q;
      tx_data_d     = IDLE_DATA;
      tx_ctrl_d     = IDLE_CTRL;
      case (state_q)
         S_IDLE: begin
            if (enable && pick_found) begin
               grant_id_d = pick_idx;
               ptr_d      = pick_idx;
               state_d    = S_XFER;
            end
         end
         S_XFER: begin
            // Underrun (granted valid low) just leaves the idle word in place
            if (hs) begin
               tx_data_d = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
               tx_ctrl_d = req_ctrl[int'(grant_id_q)*CW +: CW];
               if (req_last[grant_id_q]) begin
                  frames_sent_d = frames_sent_q + 32'd1;
                  gap_cnt_d     = GAP_INIT;
                  state_d       = (IPG_WORDS > 0) ? S_GAP : S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 4'd0) state_d = S_IDLE;
            else                   gap_cnt_d = gap_cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= GW'(NUM_SRC - 1);
         grant_id_q    <= '0;
         gap_cnt_q     <= '0;
         tx_data_q     <= IDLE_DATA;
         tx_ctrl_q     <= IDLE_CTRL;
         frames_sent_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         gap_cnt_q     <= gap_cnt_d;
         tx_data_q     <= tx_data_d;
         tx_ctrl_q     <= tx_ctrl_d;
         frames_sent_q <= frames_sent_d;
         busy_q        <= busy_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_ctrl     = tx_ctrl_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_mii_tx_frame_arbiter.sv
// Bench for mii_tx_frame_arbiter: per-source word queues feed the DUT,
// accepted words go to a scoreboard, and every non-idle lane word is
// popped and compared. Expected grant order and inter-frame idle counts
// are queued per scenario.
module tb_mii_tx_frame_arbiter;
   localparam int DW  = 64;
   localparam int NS  = 4;
   localparam int CW  = 8;
   localparam int GW  = 2;
   localparam logic [DW-1:0] IDLE_W = {CW{8'h07}};

   logic              clk, rst_n, enable;
   logic [NS-1:0]     req_valid, req_last, req_ready;
   logic [NS*DW-1:0]  req_data;
   logic [NS*CW-1:0]  req_ctrl;
   logic [DW-1:0]     tx_data;
   logic [CW-1:0]     tx_ctrl;
   logic [GW-1:0]     grant_id;
   logic              busy;
   logic [31:0]       frames_sent;

   mii_tx_frame_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .IPG_WORDS(2), .IDLE_CHAR(8'h07)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req_valid(req_valid), .req_data(req_data), .req_ctrl(req_ctrl), .req_last(req_last),
      .req_ready(req_ready), .tx_data(tx_data), .tx_ctrl(tx_ctrl), .grant_id(grant_id),
      .busy(busy), .frames_sent(frames_sent));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; logic last; logic first; } word_t;
   typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; logic first; } exp_t;

   word_t     srcq[NS][$];
   exp_t      sbq[$];
   int        ordq[$];
   logic [NS-1:0] stall;
   int checks, fails, idle_run, exp_gap, seen, frames_seen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive();
      logic [NS-1:0] v, l;
      logic [NS*DW-1:0] d;
      logic [NS*CW-1:0] c;
      v = '0; l = '0; d = '0; c = '0;
      for (int s = 0; s < NS; s++)
         if (srcq[s].size() != 0 && !stall[s]) begin
            v[s] = 1'b1;
            l[s] = srcq[s][0].last;
            d[s*DW +: DW] = srcq[s][0].d;
            c[s*CW +: CW] = srcq[s][0].c;
         end
      req_valid = v; req_last = l; req_data = d; req_ctrl = c;
   endtask

   task automatic load(input int s, input int n, input int fid);
      word_t w;
      for (int k = 0; k < n; k++) begin
         w.d = {8'(8'hA0 + s), 8'(fid), 8'(k), 8'h5A, 32'($urandom)};
         w.c = (k == 0) ? 8'h01 : ((k == n - 1) ? 8'h80 : 8'h00);
         w.first = (k == 0);
         w.last  = (k == n - 1);
         srcq[s].push_back(w);
      end
      drive();
   endtask

   // One clock: handshakes are decided mid-cycle, the lane is checked after the edge
   task automatic step();
      logic [NS-1:0] hs;
      word_t w;
      exp_t e;
      int o;
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      for (int s = 0; s < NS; s++)
         if (hs[s]) begin
            w = srcq[s].pop_front();
            sbq.push_back('{w.d, w.c, w.first});
         end
      if (tx_ctrl !== 8'hFF || tx_data !== IDLE_W) begin
         chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("tx_data", tx_data, e.d);
            chk("tx_ctrl", 64'(tx_ctrl), 64'(e.c));
            seen++;
            if (e.first) begin
               if (ordq.size() != 0) begin
                  o = ordq.pop_front();
                  chk("grant_order", 64'(grant_id), 64'(o));
               end
               if (exp_gap >= 0 && frames_seen > 0) chk("ipg_idle", 64'(idle_run), 64'(exp_gap));
               frames_seen++;
            end
         end
         idle_run = 0;
      end else idle_run++;
      drive();
   endtask

   function automatic bit pending();
      bit p = (sbq.size() != 0);
      for (int s = 0; s < NS; s++) if (srcq[s].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input int maxc);
      int n = 0;
      while (pending() && n < maxc) begin step(); n++; end
      chk("drain_timeout", 64'(n < maxc), 64'd1);
   endtask

   task automatic wait_size(input int s, input int sz, input int maxc);
      int n = 0;
      while (srcq[s].size() != sz && n < maxc) begin step(); n++; end
      chk("wait_timeout", 64'(n < maxc), 64'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int s = 0; s < NS; s++) srcq[s].delete();
      sbq.delete(); ordq.delete();
      stall = '0;
      drive();
      #2; @(posedge clk); #1;
      chk("rst_tx_data", tx_data, IDLE_W);
      chk("rst_tx_ctrl", 64'(tx_ctrl), 64'hFF);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frames", 64'(frames_sent), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b1;
      idle_run = 0; frames_seen = 0;
   endtask

   initial begin
      checks = 0; fails = 0; idle_run = 0; exp_gap = -1; seen = 0; frames_seen = 0;
      enable = 1'b1; stall = '0; rst_n = 1'b0;
      drive();
      do_reset();

      // 1: single 3-word frame, 2-cycle latency, idle tail
      load(0, 3, 1); ordq.push_back(0);
      seen = 0;
      step(); chk("t1_lat_decide", 64'(seen), 64'd0); chk("t1_busy", 64'(busy), 64'd1);
      step(); chk("t1_lat_first", 64'(seen), 64'd1);
      step(); step(); chk("t1_words", 64'(seen), 64'd3);
      idle(3);
      chk("t1_idle_tail", 64'(idle_run), 64'd3);
      chk("t1_busy_off", 64'(busy), 64'd0);
      chk("t1_frames", 64'(frames_sent), 64'd1);

      // 2: all sources request continuously, exact IPG between words
      do_reset();
      exp_gap = 3;
      load(0, 1, 10); load(1, 1, 11); load(2, 1, 12); load(3, 1, 13); load(0, 1, 14);
      ordq.push_back(0); ordq.push_back(1); ordq.push_back(2); ordq.push_back(3); ordq.push_back(0);
      drain(200); idle(4);
      chk("t2_frames", 64'(frames_sent), 64'd5);
      exp_gap = -1;

      // 3: underrun mid-frame on source 2
      load(2, 4, 20); ordq.push_back(2);
      wait_size(2, 2, 20);
      stall[2] = 1'b1; drive();
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t3_grant", 64'(grant_id), 64'd2);
         chk("t3_ready", 64'(req_ready), 64'b0100);
         chk("t3_idle_ctrl", 64'(tx_ctrl), 64'hFF);
      end
      chk("t3_idle_cnt", 64'(idle_run), 64'd2);
      stall[2] = 1'b0; drive();
      drain(50); idle(4);
      chk("t3_frames", 64'(frames_sent), 64'd6);

      // 4: enable drops mid-frame; frame and gap finish, src3 waits
      load(1, 4, 30); ordq.push_back(1);
      wait_size(1, 3, 20);
      enable = 1'b0; load(3, 1, 31);
      wait_size(1, 0, 20);
      chk("t4_busy_gap0", 64'(busy), 64'd1);
      step(); chk("t4_busy_gap1", 64'(busy), 64'd1);
      step(); chk("t4_busy_off", 64'(busy), 64'd0);
      idle(3);
      chk("t4_src3_held", 64'(srcq[3].size()), 64'd1);
      chk("t4_ready", 64'(req_ready), 64'd0);
      chk("t4_grant", 64'(grant_id), 64'd1);
      enable = 1'b1; ordq.push_back(3);
      drain(50); idle(4);
      chk("t4_frames", 64'(frames_sent), 64'd8);

      // 5: asynchronous reset mid-frame
      load(0, 4, 40); ordq.push_back(0);
      wait_size(0, 2, 20);
      rst_n = 1'b0; #1;
      chk("t5_async_busy", 64'(busy), 64'd0);
      chk("t5_async_tx", tx_data, IDLE_W);
      chk("t5_async_frames", 64'(frames_sent), 64'd0);
      do_reset();
      exp_gap = 3;
      load(1, 1, 50); load(0, 1, 51);
      ordq.push_back(0); ordq.push_back(1);
      drain(50); idle(4);
      chk("t5_frames", 64'(frames_sent), 64'd2);
      exp_gap = -1;

      // 6: frame counter wrap
      force dut.frames_sent_q = 32'hFFFF_FFFF;
      step();
      release dut.frames_sent_q;
      step();
      chk("t6_preload", 64'(frames_sent), 64'hFFFF_FFFF);
      load(2, 1, 60); ordq.push_back(2);
      drain(50); idle(2);
      chk("t6_wrap", 64'(frames_sent), 64'd0);
      chk("order_left", 64'(ordq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
